// File: rtl/ab_pattern_sequencer.sv
// Gray-order A/B pattern walker that checks the Filter's OutResult once per step.
// Optional fail counter output enabled by SEQ_FAILCNT_EN.
module ab_pattern_sequencer #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2,
  parameter int PASSES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       filt_out,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] step
`ifdef SEQ_FAILCNT_EN
  ,
  output logic [7:0] fail_cnt
`endif
);

  localparam int CW = $clog2(DWELL);
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);
  localparam logic [CW-1:0] SAMP = CW'(SETTLE);
  localparam logic [PW-1:0] PMAX = PW'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic          acc;

  logic       sample;
  logic       acc_n;
  logic       last_cnt;
  logic       last;
  logic [1:0] step_n;

  always_comb begin
    sample   = (state == RUN) && (cnt == SAMP);
    acc_n    = acc & (~sample | filt_out);
    last_cnt = (cnt == CMAX);
    last     = last_cnt && (step == 2'd3) && (pcnt == PMAX);
    step_n   = step + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      A     <= 1'b0;
      B     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      step  <= 2'd0;
      cnt   <= '0;
      pcnt  <= '0;
      acc   <= 1'b0;
`ifdef SEQ_FAILCNT_EN
      fail_cnt <= 8'd0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            pass  <= 1'b0;
            acc   <= 1'b1;
            cnt   <= '0;
            pcnt  <= '0;
            step  <= 2'd0;
            A     <= 1'b0;
            B     <= 1'b0;
`ifdef SEQ_FAILCNT_EN
            fail_cnt <= 8'd0;
`endif
          end
        end
        RUN: begin
          acc <= acc_n;
`ifdef SEQ_FAILCNT_EN
          if (sample && !filt_out && fail_cnt != 8'hFF)
            fail_cnt <= fail_cnt + 8'd1;
`endif
          if (last) begin
            state <= DN;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= acc_n;
            A     <= 1'b0;
            B     <= 1'b0;
            step  <= 2'd0;
            cnt   <= '0;
            pcnt  <= '0;
          end else if (last_cnt) begin
            cnt  <= '0;
            step <= step_n;
            // Gray code: A follows the MSB, B is MSB xor LSB
            A    <= step_n[1];
            B    <= step_n[1] ^ step_n[0];
            if (step == 2'd3)
              pcnt <= pcnt + PW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
